// File: rtl/nibble_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl_pkg
// Shared definitions for the nibble-serial adder controller.
//   - NIBBLE_W     : width of the shared adder datapath (4 bits)
//   - state_e      : 2-bit controller state encoding (IDLE/RUN/DONE)
//   - nib_count()  : number of nibbles in a WIDTH-bit operand
//   - idx_width()  : width of the nibble index counter (minimum 1 bit)
// No ports (package). Optional feature macro used by importers: SUB_EN.
// -----------------------------------------------------------------------------
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl_if
// Handshake/bus bundle between a requester/consumer and the controller.
//   in_valid/in_ready   : operation handshake (a, b, cin, and sub if SUB_EN)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : controller not idle
// Modports:
//   master : requester/consumer side (drives operands and out_ready)
//   slave  : controller side
// Optional feature macro: SUB_EN adds the sub request bit.
// -----------------------------------------------------------------------------
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_rca.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_4bit
// Purely combinational 4-bit ripple-carry adder used as the shared nibble
// datapath of nibble_serial_add_ctrl.
// Ports:
//   a_i, b_i  [3:0] : addends
//   cin_i           : carry in
//   sum_o     [3:0] : a_i + b_i + cin_i (low 4 bits)
//   cout_o          : carry out of bit 3
// -----------------------------------------------------------------------------
module ripple_carry_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Adds two WIDTH-bit operands by stepping one shared 4-bit ripple-carry adder
// across the operand nibbles, least-significant first, one nibble per clock.
// Latency from input handshake to out_valid is WIDTH/4 cycles.
// Parameters:
//   WIDTH : operand/result width, a multiple of 4 and at least 4
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_add_ctrl_if
//           (in_valid/in_ready/a/b/cin[/sub], out_valid/out_ready/sum/cout, busy)
// Optional feature macro: SUB_EN -- latches sub at accept; when set, b nibbles
// are inverted and carry starts at 1 so the result is a-b (cout=1: no borrow).
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_add_ctrl_if.slave     bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 carry_q, carry_d;
  logic [NIBBLE_W-1:0]  sum_nib_q [NIB];
`ifdef SUB_EN
  logic                 sub_q;
`endif

  logic                 accept;
  logic                 running;
  logic [IDX_W+1:0]     nib_base;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, rca_sum;
  logic                 rca_cout;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign running  = (state_q == RUN);
  // Bit offset of the current nibble: idx * 4.
  assign nib_base = {idx_q, 2'b00};
  assign a_nib    = a_q[nib_base +: NIBBLE_W];
`ifdef SUB_EN
  // Two's-complement subtract: invert b here, +1 comes from the initial carry.
  assign b_nib    = b_q[nib_base +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
  assign b_nib    = b_q[nib_base +: NIBBLE_W];
`endif

  ripple_carry_adder_4bit u_rca (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (rca_sum),
    .cout_o (rca_cout)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          idx_d   = '0;
`ifdef SUB_EN
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
        end
      end
      RUN: begin
        carry_d = rca_cout;
        // idx stays on the last nibble through DONE; it is re-zeroed at accept.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand registers: loaded only at the input handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

`ifdef SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= bus.sub;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Result nibbles: each written only on its own RUN cycle, cleared at accept
  // so a fresh operation never exposes stale upper nibbles.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NIB; gi++) begin : g_sum
    localparam logic [IDX_W-1:0] NIB_IDX = IDX_W'(gi);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_nib_q[gi] <= '0;
      end else if (accept) begin
        sum_nib_q[gi] <= '0;
      end else if (running && (idx_q == NIB_IDX)) begin
        sum_nib_q[gi] <= rca_sum;
      end
    end

    assign bus.sum[gi*NIBBLE_W +: NIBBLE_W] = sum_nib_q[gi];
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.cout      = carry_q;

endmodule
